// File: rtl/tribus_pkg.sv
// Shared types and constants for the tribus lane controller.
// Optional receive synchronizer is selected by TRIBUS_RX_SYNC_EN.
package tribus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StTurn   = 2'd2,
    StSample = 2'd3
  } state_e;

  localparam int unsigned DefDriveCycles = 2;
  localparam int unsigned DefTurnCycles  = 1;
  localparam int unsigned SyncStages     = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tribus_rx_sync.sv
// Multi-flop synchronizer for the sampled bus; only built when TRIBUS_RX_SYNC_EN is defined.
module tribus_rx_sync
  import tribus_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [SyncStages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SyncStages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SyncStages-1];

endmodule

// File: rtl/tribus_lane_ctrl.sv
// Sequencer for inverting tristate bus drivers: drive, forced turnaround, and bus sampling.
// Define TRIBUS_RX_SYNC_EN to sample the bus through a synchronizer (SAMPLE then lasts 3 cycles).
module tribus_lane_ctrl
  import tribus_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DRIVE_CYCLES = DefDriveCycles,
  parameter int unsigned TURN_CYCLES  = DefTurnCycles
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] drv_data,
  output logic             drv_en,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy
);

  logic [WIDTH-1:0] bus_samp;

`ifdef TRIBUS_RX_SYNC_EN
  localparam int unsigned SampleCycles = SyncStages + 1;

  tribus_rx_sync #(
    .Width(WIDTH)
  ) u_rx_sync (
    .clk_i (CLK),
    .rst_ni(RSTB),
    .d_i   (bus_in),
    .q_o   (bus_samp)
  );
`else
  localparam int unsigned SampleCycles = 1;

  assign bus_samp = bus_in;
`endif

  localparam int unsigned CntMax = max_u(max_u(DRIVE_CYCLES, TURN_CYCLES), SampleCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             drv_en_q, drv_en_d;
  logic [WIDTH-1:0] drv_data_q, drv_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drv_en_d   = drv_en_q;
    drv_data_d = drv_data_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    unique case (state_q)
      StIdle: begin
        // Writes win over reads; a held rx_req is picked up once the turnaround ends.
        if (tx_valid) begin
          drv_data_d = ~tx_data;
          drv_en_d   = 1'b1;
          cnt_d      = CntW'(DRIVE_CYCLES - 1);
          state_d    = StDrive;
        end else if (rx_req) begin
          cnt_d   = CntW'(SampleCycles - 1);
          state_d = StSample;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          drv_en_d = 1'b0;
          cnt_d    = CntW'(TURN_CYCLES - 1);
          state_d  = StTurn;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StTurn: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StSample: begin
        drv_en_d = 1'b0;
        if (cnt_q == '0) begin
          rx_data_d  = bus_samp;
          rx_valid_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      drv_en_q   <= 1'b0;
      drv_data_q <= '1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drv_en_q   <= drv_en_d;
      drv_data_q <= drv_data_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // tx_ready is gated by RSTB so it reads low throughout reset.
  assign tx_ready = (state_q == StIdle) && RSTB;
  assign busy     = (state_q != StIdle);
  assign drv_en   = drv_en_q;
  assign drv_data = drv_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_tribus_lane_ctrl.sv
// Self-checking bench for tribus_lane_ctrl; honours TRIBUS_RX_SYNC_EN like the design.
module tb_tribus_lane_ctrl;

  localparam int D = 2;
  localparam int T = 1;
`ifdef TRIBUS_RX_SYNC_EN
  localparam int L   = 3;
  localparam int STG = 2;
`else
  localparam int L   = 1;
  localparam int STG = 0;
`endif

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_req = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] drv_data;
  logic       drv_en;
  logic [7:0] bus_in = 8'h00;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic en_log[$];

  tribus_lane_ctrl #(
    .WIDTH       (8),
    .DRIVE_CYCLES(D),
    .TURN_CYCLES (T)
  ) dut (
    .CLK     (CLK),
    .RSTB    (RSTB),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .rx_req  (rx_req),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .drv_data(drv_data),
    .drv_en  (drv_en),
    .bus_in  (bus_in),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: tx_ready=%b required 1 after %0d cycles", tx_ready, n);
    end
  endtask

  // Write model: drv_en high in cycles 1..D, low through TURN, IDLE again at D+T+1.
  task automatic do_write(input logic [7:0] d);
    logic [7:0] inv;
    inv = ~d;
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 1; k <= D + T + 1; k++) begin
      en_log.push_back(drv_en);
      total++;
      if (drv_en !== (k <= D)) begin
        bad++;
        $display("FAIL write_drv_en: cycle %0d drv_en=%b required %b", k, drv_en, (k <= D));
      end
      total++;
      if (drv_data !== inv) begin
        bad++;
        $display("FAIL write_drv_data: cycle %0d drv_data=%h required %h", k, drv_data, inv);
      end
      total++;
      if (tx_ready !== (k == D + T + 1) || busy !== (k <= D + T)) begin
        bad++;
        $display("FAIL write_ready_busy: cycle %0d tx_ready=%b busy=%b required %b %b",
                 k, tx_ready, busy, (k == D + T + 1), (k <= D + T));
      end
      if (k < D + T + 1) step();
    end
  endtask

  // Assumes the current cycle is the IDLE cycle in which rx_req is seen (cycle 0).
  task automatic read_body(input bit vary, input logic [7:0] base);
    logic [7:0] bv[L + 2];
    for (int i = 0; i < L + 2; i++) bv[i] = vary ? 8'($urandom) : base;
    bus_in = bv[0];
    for (int k = 1; k <= L + 1; k++) begin
      step();
      bus_in = bv[k];
      total++;
      if (rx_valid !== (k == L + 1) || drv_en !== 1'b0) begin
        bad++;
        $display("FAIL read_cycle: cycle %0d rx_valid=%b drv_en=%b required %b 0",
                 k, rx_valid, drv_en, (k == L + 1));
      end
    end
    total++;
    if (rx_data !== bv[L - STG]) begin
      bad++;
      $display("FAIL read_data: rx_data=%h required %h", rx_data, bv[L - STG]);
    end
    rx_req = 1'b0;
    step();
    total++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL read_pulse: rx_valid=%b tx_ready=%b required 0 1", rx_valid, tx_ready);
    end
  endtask

  task automatic do_read(input bit vary, input logic [7:0] base);
    wait_ready();
    rx_req = 1'b1;
    read_body(vary, base);
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    repeat (3) step();
    total++;
    if (drv_en !== 1'b0 || drv_data !== 8'hFF || rx_valid !== 1'b0 || tx_ready !== 1'b0 ||
        busy !== 1'b0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: en=%b data=%h rxv=%b rdy=%b busy=%b rxd=%h required 0 ff 0 0 0 00",
               drv_en, drv_data, rx_valid, tx_ready, busy, rx_data);
    end
    RSTB = 1'b1;
    #1;
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
    end
    step();
  endtask

  task automatic test_single_write();
    do_write(8'hA5);
    total++;
    if (drv_data !== 8'h5A) begin
      bad++;
      $display("FAIL single_write_data: drv_data=%h required 5a", drv_data);
    end
  endtask

  task automatic test_simultaneous();
    wait_ready();
    rx_req = 1'b1;
    bus_in = 8'h3C;
    do_write(8'h96);
    read_body(1'b0, 8'h3C);
    total++;
    if (rx_data !== 8'h3C) begin
      bad++;
      $display("FAIL simultaneous_rx: rx_data=%h required 3c", rx_data);
    end
  endtask

  task automatic test_read_latency();
    for (int i = 0; i < 4; i++) do_read(1'b1, 8'h00);
  endtask

  task automatic test_reset_mid_drive();
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    rx_req   = 1'b1;
    step();
    tx_valid = 1'b0;
    rx_req   = 1'b0;
    total++;
    if (drv_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_drive_pre: drv_en=%b required 1", drv_en);
    end
    #2 RSTB = 1'b0;
    #1;
    total++;
    if (drv_en !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_drive_async: drv_en=%b busy=%b tx_ready=%b required 0 0 0",
               drv_en, busy, tx_ready);
    end
    repeat (2) step();
    RSTB = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (rx_valid !== 1'b0 || drv_en !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        bad++;
        $display("FAIL mid_drive_after: cycle %0d rxv=%b en=%b busy=%b rdy=%b required 0 0 0 1",
                 k, rx_valid, drv_en, busy, tx_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp[$];
    en_log.delete();
    do_write(8'h01);
    do_write(8'h02);
    total++;
    if (drv_data !== 8'hFD) begin
      bad++;
      $display("FAIL b2b_data: drv_data=%h required fd", drv_data);
    end
    // Expected stream: D high, T+1 low, D high (first write's log ends on its IDLE cycle).
    for (int i = 0; i < D; i++) exp.push_back(1'b1);
    for (int i = 0; i < T + 1; i++) exp.push_back(1'b0);
    for (int i = 0; i < D; i++) exp.push_back(1'b1);
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (en_log[i] !== exp[i]) begin
        bad++;
        $display("FAIL b2b_pattern: index %0d drv_en=%b required %b", i, en_log[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) do_write(8'($urandom));
      else                           do_read(1'b1, 8'h00);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_read_latency();
    test_reset_mid_drive();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
